// File: rtl/serial_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_sub_pkg
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding.
// -----------------------------------------------------------------------------
package serial_add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_add_sub_pkg

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational 1-bit full adder.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
// -----------------------------------------------------------------------------
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial adder/subtractor. Operands are captured on an accepted start and
// processed one bit per clock, LSB first, through a single fa_cell with a
// registered carry. Subtraction is a + ~b + 1 (carry seeded with 1).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only while idle
//   sub      : 0 = a+b, 1 = a-b (sampled with start)
//   a, b     : WIDTH-bit operands (sampled with start)
//   busy     : high whenever the FSM is not idle
//   done     : one-cycle pulse, result/cout/ovf valid
//   result   : sum/difference, held until the next accepted start
//   cout     : add: carry out; sub: 1 = no borrow
//   ovf      : two's-complement overflow
// -----------------------------------------------------------------------------
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_c;
   logic             last_bit;

   // RUN leaves at the MSB, so cnt never needs to wrap.
   assign last_bit = (cnt == CW'(WIDTH - 1));

   fa_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_s),
      .cout (fa_c)
   );

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; blocking = here would create order-dependent behaviour.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: operand/result shift registers, carry, counter, capture flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shift registers are cleared on reset too, because an
         // aborted run must not leave partial result bits on the outputs.
         a_sh   <= '0;
         b_sh   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= sub ? ~b : b;
                  carry  <= sub;
                  cnt    <= '0;
                  result <= '0;
               end
            end
            RUN: begin
               result <= {fa_s, result[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_c;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  // Overflow: carry into the sign bit differs from carry out.
                  ovf  <= carry ^ fa_c;
                  cout <= fa_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
// Scoreboard bench: an 8-bit instance for directed cases and a 4-bit instance
// for an exhaustive sweep. Expected results are computed by an integer
// reference model when a start is driven and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

   typedef struct {
      logic [7:0] res;
      logic       co;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, sub8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, result8;
   logic       start4, sub4, busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, result4;

   int   checks   = 0;
   int   failures = 0;
   int   dones8   = 0;
   int   dones4   = 0;
   exp_t q8[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(8)) u_dut8 (
      .clk    (clk),
      .rst    (rst),
      .start  (start8),
      .sub    (sub8),
      .a      (a8),
      .b      (b8),
      .busy   (busy8),
      .done   (done8),
      .result (result8),
      .cout   (cout8),
      .ovf    (ovf8)
   );

   serial_add_sub #(.WIDTH(4)) u_dut4 (
      .clk    (clk),
      .rst    (rst),
      .start  (start4),
      .sub    (sub4),
      .a      (a4),
      .b      (b4),
      .busy   (busy4),
      .done   (done4),
      .result (result4),
      .cout   (cout4),
      .ovf    (ovf4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model in plain integer arithmetic.
   function automatic exp_t model(input int w, input int a, input int b, input logic s);
      exp_t e;
      int   m, raw, sa, sb, sr;
      m    = 1 << w;
      raw  = s ? (a - b) : (a + b);
      e.res = 8'((raw + m) % m);
      e.co  = s ? (a >= b) : (raw >= m);
      sa    = (a >= m / 2) ? a - m : a;
      sb    = (b >= m / 2) ? b - m : b;
      sr    = s ? (sa - sb) : (sa + sb);
      e.ov  = (sr < -(m / 2)) || (sr >= m / 2);
      return e;
   endfunction

   // Scoreboards: every done must match the oldest pending expectation.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         exp_t e;
         dones8++;
         check("done8_expected", 32'(q8.size() > 0), 1);
         if (q8.size() > 0) begin
            e = q8.pop_front();
            check("result8", 32'(result8), 32'(e.res));
            check("cout8", 32'(cout8), 32'(e.co));
            check("ovf8", 32'(ovf8), 32'(e.ov));
         end
      end
   end

   always @(negedge clk) begin
      if (done4 === 1'b1) begin
         exp_t e;
         dones4++;
         check("done4_expected", 32'(q4.size() > 0), 1);
         if (q4.size() > 0) begin
            e = q4.pop_front();
            check("result4", 32'(result4), 32'(e.res));
            check("cout4", 32'(cout4), 32'(e.co));
            check("ovf4", 32'(ovf4), 32'(e.ov));
         end
      end
   end

   // Called at a negedge; the start is sampled at the next posedge (edge 0).
   // Returns at the negedge after edge 0.
   task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit push);
      a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
      if (push) q8.push_back(model(8, int'(a), int'(b), s));
      @(negedge clk);
      start8 = 1'b0;
   endtask

   // Waits for done8; base is the last edge index already passed.
   task automatic wait_done8(input int base, output int edge_idx);
      bit seen = 1'b0;
      edge_idx = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done8 === 1'b1) begin
            seen     = 1'b1;
            edge_idx = base + i + 1;
         end
      end
      check("done8_seen", 32'(seen), 1);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
      int e;
      start_op8(a, b, s, 1'b1);
      check("busy8_after_start", 32'(busy8), 1);
      wait_done8(0, e);
      check("done8_latency", 32'(e), 8);
      @(negedge clk);
      check("busy8_after_done", 32'(busy8), 0);
   endtask

   initial begin
      int e, d0, seen;
      rst = 1'b1;
      start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy8), 0);
      check("rst_done", 32'(done8), 0);
      check("rst_result", 32'(result8), 0);
      check("rst_cout", 32'(cout8), 0);
      check("rst_ovf", 32'(ovf8), 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed arithmetic cases.
      op8(8'h05, 8'h03, 1'b0);
      op8(8'hFF, 8'h01, 1'b0);
      op8(8'h7F, 8'h01, 1'b0);
      op8(8'h05, 8'h07, 1'b1);
      op8(8'h80, 8'h01, 1'b1);
      op8(8'hA5, 8'h5A, 1'b1);
      op8(8'h00, 8'h00, 1'b1);

      // Start while busy is ignored; only one done; next start at edge 10.
      d0 = dones8;
      start_op8(8'h05, 8'h03, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      a8 = 8'h11; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(3, e);
      check("ignored_start_latency", 32'(e), 8);
      @(negedge clk);
      check("busy8_edge9", 32'(busy8), 0);
      check("single_done", 32'(dones8 - d0), 1);
      start_op8(8'h22, 8'h01, 1'b0, 1'b1);
      check("start_edge10_accepted", 32'(busy8), 1);
      wait_done8(0, e);
      check("edge10_latency", 32'(e), 8);
      @(negedge clk);

      // Reset at edge 4 of a run aborts it with no done.
      d0 = dones8;
      start_op8(8'h05, 8'h03, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(busy8), 0);
      check("midrst_done", 32'(done8), 0);
      check("midrst_result", 32'(result8), 0);
      check("midrst_cout", 32'(cout8), 0);
      check("midrst_ovf", 32'(ovf8), 0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("midrst_no_done", 32'(dones8 - d0), 0);
      op8(8'h10, 8'h20, 1'b0);

      // Exhaustive 4-bit sweep.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int is = 0; is < 2; is++) begin
               a4 = 4'(ia); b4 = 4'(ib); sub4 = 1'(is); start4 = 1'b1;
               q4.push_back(model(4, ia, ib, 1'(is)));
               @(negedge clk);
               start4 = 1'b0;
               seen = 0;
               for (int c = 0; c < 20 && seen == 0; c++) begin
                  @(negedge clk);
                  if (done4 === 1'b1) seen = 1;
               end
               if (seen == 0) check("done4_seen", 0, 1);
               @(negedge clk);
            end
         end
      end

      check("q8_drained", 32'(q8.size()), 0);
      check("q4_drained", 32'(q4.size()), 0);
      check("dones4_total", 32'(dones4), 512);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_serial_add_sub
